stream_frame_rx: RTL and testbench

- Downstream consumer of the byte-stream sender in the simulation utility set.
- Accepts a byte stream on din/vin and throttles the producer through cts.
- Assembles one frame into an internal buffer. End of frame is detected by an idle gap.
- Checks the Ethernet FCS, reports length and status, and plays the frame back through a read port for scoreboarding.

---
 rtl/stream_rx_pkg.sv | 25 ++
 rtl/rx_buf_ram.sv | 32 +++
 rtl/stream_frame_rx.sv | 199 +++++++++++++++++++
 tb/tb_stream_frame_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rx_pkg.sv
// Shared types and CRC-32 helpers for the stream frame receiver.
package stream_rx_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_HOLD = 2'd2,
        RX_DROP = 2'd3
    } rx_state_e;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    // Reflected CRC-32 update over one byte, LSB first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_buf_ram.sv
// Simple dual-port frame buffer, DEPTH x 8, registered read with one-cycle latency.
module rx_buf_ram #(
    parameter int unsigned DEPTH = 2048
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [7:0]                 wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [7:0]                 rdata
);

    logic [7:0] mem [DEPTH];

    // Contents are never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stream_frame_rx.sv
// Byte-stream frame receiver: buffers one gap-terminated frame, checks its FCS
// residue and plays it back through a read port.
module stream_frame_rx
    import stream_rx_pkg::*;
#(
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned MIN_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               din,
    input  logic                     vin,
    output logic                     cts,
    output logic                     frm_val,
    output logic [$clog2(DEPTH):0]   frm_len,
    output logic                     frm_crc_ok,
    output logic                     frm_err,
    output logic                     drop,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_vld,
    output logic                     rd_last
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned GW = $clog2(GAP_CYC + 1);

    localparam logic [1:0] ST_IDLE = RX_IDLE;
    localparam logic [1:0] ST_RECV = RX_RECV;
    localparam logic [1:0] ST_HOLD = RX_HOLD;
    localparam logic [1:0] ST_DROP = RX_DROP;

    logic [1:0]    state,   state_nxt;
    logic [PW-1:0] wr_ptr,  wr_ptr_nxt;
    logic [PW-1:0] rd_ptr,  rd_ptr_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [31:0]   crc,     crc_nxt;
    logic          cts_nxt;
    logic          frm_val_nxt;
    logic [PW-1:0] frm_len_nxt;
    logic          frm_crc_ok_nxt;
    logic          frm_err_nxt;
    logic          drop_nxt;
    logic          rd_vld_nxt;
    logic          rd_last_nxt;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic          gap_done_c;
    logic          last_rd_c;

    assign gap_done_c = (gap_cnt == GW'(GAP_CYC - 1));
    assign last_rd_c  = ((rd_ptr + PW'(1)) == frm_len);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            gap_cnt    <= '0;
            crc        <= '0;
            cts        <= 1'b0;
            frm_val    <= 1'b0;
            frm_len    <= '0;
            frm_crc_ok <= 1'b0;
            frm_err    <= 1'b0;
            drop       <= 1'b0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            gap_cnt    <= gap_nxt;
            crc        <= crc_nxt;
            cts        <= cts_nxt;
            frm_val    <= frm_val_nxt;
            frm_len    <= frm_len_nxt;
            frm_crc_ok <= frm_crc_ok_nxt;
            frm_err    <= frm_err_nxt;
            drop       <= drop_nxt;
            rd_vld     <= rd_vld_nxt;
            rd_last    <= rd_last_nxt;
        end
    end

    // Next-state, buffer control and output decode.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        gap_nxt        = gap_cnt;
        crc_nxt        = crc;
        frm_val_nxt    = frm_val;
        frm_len_nxt    = frm_len;
        frm_crc_ok_nxt = frm_crc_ok;
        frm_err_nxt    = frm_err;
        drop_nxt       = 1'b0;
        rd_vld_nxt     = 1'b0;
        rd_last_nxt    = 1'b0;
        ram_we         = 1'b0;
        ram_waddr      = wr_ptr[AW-1:0];
        ram_re         = 1'b0;
        ram_raddr      = rd_ptr[AW-1:0];

        case (state)
            ST_IDLE: begin
                if (vin) begin
                    ram_we     = 1'b1;
                    ram_waddr  = '0;
                    wr_ptr_nxt = PW'(1);
                    crc_nxt    = crc32_byte(CRC32_INIT, din);
                    gap_nxt    = '0;
                    state_nxt  = ST_RECV;
                end
            end

            ST_RECV: begin
                if (vin) begin
                    gap_nxt = '0;
                    if (wr_ptr == PW'(DEPTH)) begin
                        drop_nxt  = 1'b1;
                        state_nxt = ST_DROP;
                    end else begin
                        ram_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        crc_nxt    = crc32_byte(crc, din);
                    end
                end else if (gap_done_c) begin
                    frm_val_nxt    = 1'b1;
                    frm_len_nxt    = wr_ptr;
                    frm_crc_ok_nxt = (crc == CRC32_RESIDUE);
                    frm_err_nxt    = (wr_ptr < PW'(MIN_LEN));
                    rd_ptr_nxt     = '0;
                    gap_nxt        = '0;
                    state_nxt      = ST_HOLD;
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end

            ST_DROP: begin
                if (vin) begin
                    gap_nxt = '0;
                end else if (gap_done_c) begin
                    gap_nxt    = '0;
                    wr_ptr_nxt = '0;
                    crc_nxt    = '0;
                    state_nxt  = ST_IDLE;
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end

            ST_HOLD: begin
                // Bytes arriving while cts is low are producer skew and are discarded.
                drop_nxt = vin;
                if (rd_en && (rd_ptr < frm_len)) begin
                    ram_re      = 1'b1;
                    rd_ptr_nxt  = rd_ptr + PW'(1);
                    rd_vld_nxt  = 1'b1;
                    rd_last_nxt = last_rd_c;
                    if (last_rd_c) begin
                        frm_val_nxt = 1'b0;
                        wr_ptr_nxt  = '0;
                        rd_ptr_nxt  = '0;
                        crc_nxt     = '0;
                        state_nxt   = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        cts_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_RECV);
    end

    rx_buf_ram #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (din),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_stream_frame_rx.sv
// Directed self-checking bench for stream_frame_rx.
module tb_stream_frame_rx;

    localparam int unsigned DEPTH   = 2048;
    localparam int unsigned GAP_CYC = 2;
    localparam int unsigned MIN_LEN = 4;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        vin = 1'b0;
    logic        rd_en = 1'b0;
    logic        cts, frm_val, frm_crc_ok, frm_err, drop, rd_vld, rd_last;
    logic [11:0] frm_len;
    logic [7:0]  rd_data;

    int n_chk  = 0;
    int n_pass = 0;
    int drop_cnt = 0;
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic       rxl [$];

    always #5 clk = ~clk;

    stream_frame_rx #(
        .DEPTH   (DEPTH),
        .GAP_CYC (GAP_CYC),
        .MIN_LEN (MIN_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .vin        (vin),
        .cts        (cts),
        .frm_val    (frm_val),
        .frm_len    (frm_len),
        .frm_crc_ok (frm_crc_ok),
        .frm_err    (frm_err),
        .drop       (drop),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .rd_last    (rd_last)
    );

    // Passive monitor: drop pulses and readback bytes.
    always @(negedge clk) begin
        if (drop === 1'b1) drop_cnt++;
        if (rd_vld === 1'b1) begin
            rxq.push_back(rd_data);
            rxl.push_back(rd_last);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bit-serial reference CRC over the current transmit queue.
    function automatic logic [31:0] model_crc();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (txq[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ txq[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic build_frame(input int n_pay, input logic [7:0] last_xor);
        logic [31:0] fcs;
        txq.delete();
        for (int i = 0; i < n_pay; i++) txq.push_back(8'(i));
        fcs = ~model_crc();
        txq.push_back(fcs[7:0]);
        txq.push_back(fcs[15:8]);
        txq.push_back(fcs[23:16]);
        txq.push_back(fcs[31:24] ^ last_xor);
    endtask

    task automatic send(input int gap_at);
        foreach (txq[i]) begin
            if (i == gap_at) begin
                vin = 1'b0;
                @(posedge clk); #1;
            end
            din = txq[i];
            vin = 1'b1;
            @(posedge clk); #1;
        end
        vin = 1'b0;
        din = 8'h00;
    endtask

    task automatic expect_frame(input string tag);
        int len;
        len = txq.size();
        @(posedge clk); #1;
        check({tag, "_val_early"}, frm_val, 0);
        @(posedge clk); #1;
        check({tag, "_val"}, frm_val, 1);
        check({tag, "_cts_low"}, cts, 0);
        check({tag, "_len"}, 32'(frm_len), 32'(len));
        check({tag, "_crc_ok"}, frm_crc_ok, (model_crc() == RESIDUE) ? 1 : 0);
        check({tag, "_err"}, frm_err, (len < MIN_LEN) ? 1 : 0);
    endtask

    task automatic read_all(input string tag);
        int n, base, mism, lasts;
        n    = txq.size();
        base = rxq.size();
        rd_en = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
        check({tag, "_rd_val_clr"}, frm_val, 0);
        check({tag, "_rd_cts"}, cts, 1);
        check({tag, "_rd_vld_last"}, rd_vld, 1);
        check({tag, "_rd_last"}, rd_last, 1);
        @(posedge clk); #1;
        check({tag, "_rd_vld_off"}, rd_vld, 0);
        check({tag, "_rd_count"}, 32'(rxq.size() - base), 32'(n));
        mism  = 0;
        lasts = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i >= rxq.size()) begin
                mism++;
            end else begin
                if (rxq[base + i] !== txq[i]) mism++;
                if (rxl[base + i] === 1'b1) lasts++;
            end
        end
        check({tag, "_rd_data"}, 32'(mism), 0);
        check({tag, "_rd_last_cnt"}, 32'(lasts), 1);
    endtask

    initial begin
        int d0, base;

        // Reset state
        #1 rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_cts", cts, 0);
        check("rst_val", frm_val, 0);
        check("rst_drop", drop, 0);
        check("rst_rd_vld", rd_vld, 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_len", 32'(frm_len), 0);
        @(negedge clk) rst = 1'b1;
        #1 check("rst_rel_cts0", cts, 0);
        @(posedge clk); #1;
        check("rst_rel_cts1", cts, 1);

        // Valid 64-byte frame
        build_frame(60, 8'h00);
        send(-1);
        expect_frame("good");
        read_all("good");

        // rd_en outside HOLD is ignored
        base  = rxq.size();
        rd_en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
        check("idle_rd_ignored", 32'(rxq.size() - base), 0);

        // Corrupted FCS
        build_frame(60, 8'h01);
        send(-1);
        expect_frame("badfcs");
        check("badfcs_ok_const", frm_crc_ok, 0);
        read_all("badfcs");

        // Short frame
        txq.delete();
        txq.push_back(8'hAA);
        txq.push_back(8'hBB);
        txq.push_back(8'hCC);
        send(-1);
        expect_frame("short");
        check("short_err_const", frm_err, 1);
        read_all("short");

        // Mid-frame gap shorter than GAP_CYC
        txq.delete();
        for (int i = 0; i < 20; i++) txq.push_back(8'(8'h80 + i));
        send(10);
        expect_frame("gap");
        read_all("gap");

        // Overflow: DEPTH+1 bytes
        txq.delete();
        for (int i = 0; i <= int'(DEPTH); i++) txq.push_back(8'(i * 3));
        d0 = drop_cnt;
        send(-1);
        check("ovf_drop_pulse", drop, 1);
        @(posedge clk); #1;
        check("ovf_val0", frm_val, 0);
        @(posedge clk); #1;
        check("ovf_val1", frm_val, 0);
        check("ovf_cts_idle", cts, 1);
        check("ovf_drop_cnt", 32'(drop_cnt - d0), 1);
        build_frame(60, 8'h00);
        send(-1);
        expect_frame("after_ovf");
        read_all("after_ovf");

        // Producer skew: two bytes during HOLD
        build_frame(60, 8'h00);
        send(-1);
        expect_frame("skew");
        d0  = drop_cnt;
        din = 8'hEE;
        vin = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        vin = 1'b0;
        @(posedge clk); #1;
        check("skew_drops", 32'(drop_cnt - d0), 2);
        check("skew_len", 32'(frm_len), 64);
        check("skew_val", frm_val, 1);
        read_all("skew");

        // Reset in the middle of a frame
        build_frame(60, 8'h00);
        d0 = drop_cnt;
        for (int i = 0; i < 30; i++) begin
            din = txq[i];
            vin = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("midrst_cts", cts, 0);
        check("midrst_val", frm_val, 0);
        vin = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_cts_up", cts, 1);
        check("midrst_no_drop", 32'(drop_cnt - d0), 0);
        send(-1);
        expect_frame("post_rst");
        read_all("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
